// File: rtl/dmac_pkg.sv
// Shared definitions for the DMA descriptor engine: state encoding and field widths.
package dmac_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned SIZE_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } dmac_state_e;

endpackage

// File: rtl/dmac_engine_ns.sv
// Next-state logic for the DMA descriptor engine FSM (purely combinational).
module dmac_engine_ns
    import dmac_pkg::*;
(
    input  logic [2:0]        state,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic              fifo_rd_ack,
    input  logic [SIZE_W-1:0] fifo_size,
    input  logic              m_ack,
    input  logic [SIZE_W-1:0] count,
    output logic [2:0]        state_nxt
);

    dmac_state_e cur;
    dmac_state_e nxt;

    assign cur       = dmac_state_e'(state);
    assign state_nxt = nxt;

    always_comb begin
        nxt = cur;
        case (cur)
            ST_IDLE:  if (enable && !fifo_empty) nxt = ST_POP;
            ST_POP:   nxt = ST_LOAD;
            ST_LOAD: begin
                if (!fifo_rd_ack)          nxt = ST_IDLE;
                else if (fifo_size == '0)  nxt = ST_DONE;
                else                       nxt = ST_READ;
            end
            ST_READ:  if (m_ack) nxt = ST_WRITE;
            // Count still holds the pre-decrement value here, so 1 means last word.
            ST_WRITE: if (m_ack) nxt = (count == SIZE_W'(1)) ? ST_DONE : ST_READ;
            ST_DONE:  nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/dmac_engine.sv
// DMA descriptor engine: pops descriptors, copies words read-then-write, pulses desc_done.
// Optional completion interrupt enabled by defining DMAC_ENGINE_INTR_EN.
module dmac_engine
    import dmac_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic              fifo_rd_ack,
    input  logic [15:0]       fifo_src,
    input  logic [15:0]       fifo_dst,
    input  logic [15:0]       fifo_size,
    output logic              fifo_rd_en,
    output logic              m_req,
    output logic              m_wr,
    output logic [15:0]       m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              busy,
    output logic              desc_done,
    output logic              intr,
    input  logic              intr_clr
);

    dmac_state_e       state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [SIZE_W-1:0] cnt_q;
    logic [DATA_W-1:0] buf_q;

    dmac_engine_ns u_ns (
        .state       (state),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_rd_ack (fifo_rd_ack),
        .fifo_size   (fifo_size),
        .m_ack       (m_ack),
        .count       (cnt_q),
        .state_nxt   (state_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            src_q <= '0;
            dst_q <= '0;
            cnt_q <= '0;
            buf_q <= '0;
        end else begin
            state <= dmac_state_e'(state_nxt);
            case (state)
                ST_LOAD: begin
                    if (fifo_rd_ack) begin
                        src_q <= fifo_src;
                        dst_q <= fifo_dst;
                        cnt_q <= fifo_size;
                    end
                end
                ST_READ:  if (m_ack) buf_q <= m_rdata;
                ST_WRITE: begin
                    if (m_ack) begin
                        src_q <= src_q + ADDR_W'(1);
                        dst_q <= dst_q + ADDR_W'(1);
                        cnt_q <= cnt_q - SIZE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        fifo_rd_en = (state == ST_POP);
        m_req      = (state == ST_READ) || (state == ST_WRITE);
        m_wr       = (state == ST_WRITE);
        busy       = (state != ST_IDLE);
        desc_done  = (state == ST_DONE);
        m_addr     = '0;
        m_wdata    = '0;
        if (state == ST_READ) m_addr = src_q;
        if (state == ST_WRITE) begin
            m_addr  = dst_q;
            m_wdata = buf_q;
        end
    end

`ifdef DMAC_ENGINE_INTR_EN
    // Set has priority over clear when both land in the DONE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                intr <= 1'b0;
        else if (state == ST_DONE)   intr <= 1'b1;
        else if (intr_clr)           intr <= 1'b0;
    end
`else
    logic intr_clr_unused;
    assign intr_clr_unused = intr_clr;
    assign intr            = 1'b0;
`endif

endmodule

// File: doc/dmac_engine.md
DMAC_ENGINE -- requirements
Module: dmac_engine

Interface
REQ-001 Parameter: DATA_W, default 32, bus data word width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  engine may pop new descriptors while high.
REQ-005 fifo_empty  input  1  descriptor FIFO empty flag.
REQ-006 fifo_rd_ack  input  1  FIFO read acknowledge; valid the cycle after fifo_rd_en.
REQ-007 fifo_src / fifo_dst / fifo_size  input  16 each  registered FIFO outputs: source addr, dest addr, word count.
REQ-008 fifo_rd_en  output  1  one-cycle descriptor pop request.
REQ-009 m_req  output  1  bus request.
REQ-010 m_wr  output  1  1 = write, 0 = read.
REQ-011 m_addr  output  16  bus word address.
REQ-012 m_wdata  output  DATA_W  write data.
REQ-013 m_rdata  input  DATA_W  read data, valid with m_ack.
REQ-014 m_ack  input  1  slave accepts the current transaction this cycle.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 desc_done  output  1  one-cycle pulse per completed or discarded descriptor.
REQ-017 intr  output  1  completion interrupt (see Configuration).
REQ-018 intr_clr  input  1  clears intr.

Function
REQ-019 Moore FSM, states IDLE, POP, LOAD, READ, WRITE, DONE; all outputs decoded from registered state and datapath registers.
REQ-020 IDLE -> POP when enable=1 and fifo_empty=0; otherwise stays in IDLE.
REQ-021 POP: fifo_rd_en=1 for exactly this cycle; unconditional transition -> LOAD.
REQ-022 LOAD: if fifo_rd_ack=0 -> IDLE with nothing captured; otherwise capture src, dst, size into internal registers; size=0 -> DONE, else -> READ.
REQ-023 READ: m_req=1, m_wr=0, m_addr=src; held until m_ack=1, then m_rdata is latched into the data buffer -> WRITE.
REQ-024 WRITE: m_req=1, m_wr=1, m_addr=dst, m_wdata=buffer; on m_ack: src+1, dst+1, count-1; if the count before decrement is 1 -> DONE, else -> READ.
REQ-025 Addresses are 16-bit modulo: 16'hFFFF + 1 = 16'h0000, with no error raised.
REQ-026 Count is 16-bit unsigned; size 16'hFFFF transfers 65535 words.
REQ-027 DONE: desc_done=1 for one cycle -> IDLE.
REQ-028 enable=0 mid-descriptor does not abort; it only blocks the next pop.
REQ-029 Minimum latency for a 1-word descriptor with same-cycle acks: POP, LOAD, READ, WRITE, DONE (5 cycles after leaving IDLE).
REQ-030 m_req=0, m_wr=0 and fifo_rd_en=0 outside the states named above.

Reset
REQ-031 reset_n=0 immediately forces IDLE, including mid-transfer; the in-flight descriptor is abandoned.
REQ-032 Reset values: all address, count and buffer registers 0; every output 0.

Configuration
REQ-033 Macro DMAC_ENGINE_INTR_EN defined: intr is set on the DONE cycle and held until the cycle after intr_clr=1.
REQ-034 If set and clear occur in the same cycle, set wins.
REQ-035 Macro not defined: intr is tied to 0 and intr_clr is ignored; the ports still exist.

Structure
REQ-036 Shared package dmac_pkg: state encoding constants (3-bit), ADDR_W=16, SIZE_W=16.
REQ-037 The next-state logic is a separate combinational sub-module, dmac_engine_ns.
REQ-038 Registers, datapath and output decode live in dmac_engine.

Verification
REQ-039 FIFO holds src=0x0010, dst=0x0100, size=3, acks same-cycle -> reads 0x0010/11/12 each followed by writes 0x0100/01/02 with matching data; one desc_done.
REQ-040 size=0 descriptor -> POP, LOAD, DONE; m_req never asserted; desc_done pulses once.
REQ-041 src=0xFFFF, size=2 -> second read address 0x0000.
REQ-042 m_ack delayed 3 cycles on each access -> m_req and m_addr held stable until ack; data preserved.
REQ-043 reset_n low during WRITE of word 2 -> all outputs 0 asynchronously; after release, IDLE; with fifo_empty=1, no pop occurs.
REQ-044 With DMAC_ENGINE_INTR_EN: intr rises on DONE and falls the cycle after intr_clr=1; without the macro, intr stays 0.
